// File: rtl/latch_write_arbiter.sv
// Arbitrates N requesters for one shared level-sensitive latch and sequences its data/gate inputs.
// Define LATCH_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
//
// state | meaning
// IDLE  | no transaction; arbitrate req, grant winner and capture its data
// SETUP | latch_d stable, gate closed for one cycle
// GATE  | latch gate open for GATE_CYCLES cycles
// HOLD  | gate closed, data still stable, done pulses to the winner
module latch_write_arbiter #(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int GATE_CYCLES = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic           latch_en,
  output logic [W-1:0]   latch_d
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GATE_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_GATE  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  r_done;
  logic          r_busy;
  logic          r_latch_en;
  logic [W-1:0]  r_latch_d;

  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic [N-1:0]  w_onehot;
  logic [W-1:0]  w_sel;

`ifdef LATCH_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_ptr_nxt;
`endif

  // Search order starts at the pointer (round-robin) or at index 0 (fixed priority).
  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_idx    = '0;
    w_onehot = '0;
    w_sel    = '0;
`ifdef LATCH_ARB_ROUND_ROBIN_EN
    w_sum    = '0;
`endif
    for (int k = 0; k < N; k++) begin
`ifdef LATCH_ARB_ROUND_ROBIN_EN
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_idx = w_sum[IW-1:0];
`else
      w_idx = IW'(k);
`endif
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_onehot[w_win] = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == w_win) w_sel = wdata[k*W +: W];
    end
  end

`ifdef LATCH_ARB_ROUND_ROBIN_EN
  assign w_ptr_nxt = (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_latch_en <= 1'b0;
      r_latch_d  <= '0;
`ifdef LATCH_ARB_ROUND_ROBIN_EN
      r_ptr      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state   <= S_SETUP;
            r_grant   <= w_onehot;
            r_busy    <= 1'b1;
            r_latch_d <= w_sel;
`ifdef LATCH_ARB_ROUND_ROBIN_EN
            r_ptr     <= w_ptr_nxt;
`endif
          end
        end
        S_SETUP: begin
          r_state    <= S_GATE;
          r_cnt      <= '0;
          r_latch_en <= 1'b1;
        end
        S_GATE: begin
          // Gate closes one full cycle before latch_d is allowed to change again.
          if (r_cnt == CNT_LAST) begin
            r_state    <= S_HOLD;
            r_latch_en <= 1'b0;
            r_done     <= r_grant;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant    = r_grant;
  assign done     = r_done;
  assign busy     = r_busy;
  assign latch_en = r_latch_en;
  assign latch_d  = r_latch_d;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: N=4, W=8, one instance with GATE_CYCLES=2 and one with 1.
// Expected grant/data pairs go into a scoreboard queue and are checked against each done pulse.
module tb_latch_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;

  logic [3:0]  grant, done, g1_grant, g1_done;
  logic        busy, latch_en, g1_busy, g1_latch_en;
  logic [7:0]  latch_d, g1_latch_d;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_ptr = 0;

  latch_write_arbiter #(.N(4), .W(8), .GATE_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant), .done(done), .busy(busy), .latch_en(latch_en), .latch_d(latch_d)
  );

  latch_write_arbiter #(.N(4), .W(8), .GATE_CYCLES(1)) dut_g1 (
    .clock(clock), .reset(reset), .req(req), .wdata(wdata),
    .grant(g1_grant), .done(g1_done), .busy(g1_busy), .latch_en(g1_latch_en),
    .latch_d(g1_latch_d)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_steps(input int n);
    req = 4'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0;
    wdata = 32'h0;
    step();
    step();
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
    total++; if (done !== 4'b0) begin bad++; $display("FAIL reset_done got=%b want=0000", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (latch_en !== 1'b0) begin bad++; $display("FAIL reset_latch_en got=%b want=0", latch_en); end
    total++; if (latch_d !== 8'h00) begin bad++; $display("FAIL reset_latch_d got=%h want=00", latch_d); end
    total++; if (g1_latch_en !== 1'b0) begin bad++; $display("FAIL reset_g1_latch_en got=%b want=0", g1_latch_en); end
    m_ptr = 0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_contention();
    int         ngrant, ndone, last, cyc, w;
    logic [3:0] prevg;
    exp_t       e;
    ngrant = 0; ndone = 0; last = -1; cyc = 0;
    prevg  = grant;
    wdata  = {8'h13, 8'h12, 8'h11, 8'h10};
    req    = 4'b1111;
    while (ndone < 5 && cyc < 60) begin
      step();
      cyc++;
      if (grant != 4'b0 && prevg == 4'b0) begin
`ifdef LATCH_ARB_ROUND_ROBIN_EN
        w = m_ptr;
        m_ptr = (m_ptr + 1) % 4;
`else
        w = 0;
`endif
        e.g = 4'b0001 << w;
        e.d = 8'h10 + 8'(w);
        sb.push_back(e);
        total++;
        if (grant !== e.g) begin bad++; $display("FAIL contention_grant#%0d got=%b want=%b", ngrant, grant, e.g); end
        if (last >= 0) begin
          total++;
          if (cyc - last != 5) begin bad++; $display("FAIL contention_period got=%0d want=5", cyc - last); end
        end
        last = cyc;
        ngrant++;
        if (ngrant == 5) req = 4'b0;
      end
      if (done != 4'b0) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL contention_sb_empty got=done %b want=queued entry", done);
        end else begin
          e = sb.pop_front();
          if (done !== e.g || latch_d !== e.d) begin
            bad++;
            $display("FAIL contention_done got=%b/%h want=%b/%h", done, latch_d, e.g, e.d);
          end
        end
        ndone++;
      end
      prevg = grant;
    end
    total++; if (ndone != 5) begin bad++; $display("FAIL contention_timeout got=%0d dones want=5", ndone); end
    idle_steps(4);
  endtask

  task automatic run_txn(input logic [3:0] rq, input logic [31:0] wd, input logic [31:0] wd2,
                         input logic [3:0] exp_g, input logic [7:0] exp_d, input string nm);
    logic [3:0] eg, ed;
    logic       eb, een;
    int         ndone;
    exp_t       e;
    ndone = 0;
    e.g = exp_g;
    e.d = exp_d;
    sb.push_back(e);
    wdata = wd;
    req   = rq;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) req = 4'b0;
      if (c == 2) wdata = wd2;
      eg  = (c <= 4) ? exp_g : 4'b0;
      eb  = (c <= 4);
      een = (c == 2 || c == 3);
      ed  = (c == 4) ? exp_g : 4'b0;
      total++; if (grant !== eg) begin bad++; $display("FAIL %s_grant c%0d got=%b want=%b", nm, c, grant, eg); end
      total++; if (busy !== eb) begin bad++; $display("FAIL %s_busy c%0d got=%b want=%b", nm, c, busy, eb); end
      total++; if (latch_en !== een) begin bad++; $display("FAIL %s_latch_en c%0d got=%b want=%b", nm, c, latch_en, een); end
      total++; if (done !== ed) begin bad++; $display("FAIL %s_done c%0d got=%b want=%b", nm, c, done, ed); end
      total++; if (latch_d !== exp_d) begin bad++; $display("FAIL %s_latch_d c%0d got=%h want=%h", nm, c, latch_d, exp_d); end
      if (done != 4'b0) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL %s_sb_empty got=done %b want=queued entry", nm, done);
        end else begin
          e = sb.pop_front();
          if (done !== e.g || latch_d !== e.d) begin
            bad++; $display("FAIL %s_sb got=%b/%h want=%b/%h", nm, done, latch_d, e.g, e.d);
          end
        end
        ndone++;
      end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL %s_done_count got=%0d want=1", nm, ndone); end
    idle_steps(3);
  endtask

  task automatic test_single();
    run_txn(4'b0010, {8'h00, 8'h00, 8'hA5, 8'h00}, {8'h00, 8'h00, 8'h3C, 8'h00},
            4'b0010, 8'hA5, "single");
`ifdef LATCH_ARB_ROUND_ROBIN_EN
    m_ptr = 2;
`endif
  endtask

  task automatic test_early_deassert();
    run_txn(4'b0100, {8'h00, 8'h77, 8'h00, 8'h00}, {8'hFF, 8'hC3, 8'hFF, 8'hFF},
            4'b0100, 8'h77, "early");
`ifdef LATCH_ARB_ROUND_ROBIN_EN
    m_ptr = 3;
`endif
  endtask

  task automatic test_reset_mid();
    int sawdone;
    wdata = {8'h00, 8'h99, 8'h00, 8'h00};
    req   = 4'b0100;
    step();
    req = 4'b0;
    step();
    total++; if (latch_en !== 1'b1) begin bad++; $display("FAIL rstmid_pre_latch_en got=%b want=1", latch_en); end
    reset = 1'b1;
    step();
    total++; if (latch_en !== 1'b0) begin bad++; $display("FAIL rstmid_latch_en got=%b want=0", latch_en); end
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL rstmid_grant got=%b want=0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (latch_d !== 8'h00) begin bad++; $display("FAIL rstmid_latch_d got=%h want=00", latch_d); end
    reset = 1'b0;
    m_ptr = 0;
    sawdone = 0;
    if (done != 4'b0) sawdone++;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done != 4'b0) sawdone++;
    end
    total++; if (sawdone != 0) begin bad++; $display("FAIL rstmid_done_seen got=%0d want=0", sawdone); end
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    req   = 4'b1111;
    step();
    req = 4'b0;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rstmid_regrant got=%b want=0001", grant); end
    total++; if (latch_d !== 8'h10) begin bad++; $display("FAIL rstmid_regrant_d got=%h want=10", latch_d); end
`ifdef LATCH_ARB_ROUND_ROBIN_EN
    m_ptr = 1;
`endif
    idle_steps(6);
  endtask

  task automatic test_gate1();
    logic [3:0] eg, ed;
    logic       een;
    int         ndone;
    exp_t       e;
    ndone = 0;
    e.g = 4'b0001;
    e.d = 8'h42;
    sb.push_back(e);
    wdata = {8'h00, 8'h00, 8'h00, 8'h42};
    req   = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) req = 4'b0;
      eg  = (c <= 3) ? 4'b0001 : 4'b0;
      een = (c == 2);
      ed  = (c == 3) ? 4'b0001 : 4'b0;
      total++; if (g1_grant !== eg) begin bad++; $display("FAIL g1_grant c%0d got=%b want=%b", c, g1_grant, eg); end
      total++; if (g1_latch_en !== een) begin bad++; $display("FAIL g1_latch_en c%0d got=%b want=%b", c, g1_latch_en, een); end
      total++; if (g1_done !== ed) begin bad++; $display("FAIL g1_done c%0d got=%b want=%b", c, g1_done, ed); end
      if (g1_done != 4'b0) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL g1_sb_empty got=done %b want=queued entry", g1_done);
        end else begin
          e = sb.pop_front();
          if (g1_done !== e.g || g1_latch_d !== e.d) begin
            bad++; $display("FAIL g1_sb got=%b/%h want=%b/%h", g1_done, g1_latch_d, e.g, e.d);
          end
        end
        ndone++;
      end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL g1_done_count got=%0d want=1", ndone); end
    idle_steps(4);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_early_deassert();
    test_reset_mid();
    test_gate1();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/latch_write_arbiter.md
# latch_write_arbiter

Sequencer and arbiter for one shared level-sensitive D-latch register. Up to N requesters compete to write the latch. The block grants one requester at a time, registers that requester's data, and drives the latch's data and gate (clock) inputs. The gate only opens while the data is already stable and closes before the data may change, so the latch is never transparent to a changing input. It sits between the requesting units and the `LatchD`-style storage element, and is the only driver of that element's `clock` and `d`.

## Interface
- `N`, 4, number of requesters (≥2)
- `W`, 8, data width of the shared latch
- `GATE_CYCLES`, 2, cycles the latch gate stays high per write (≥1)

- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  N  per-requester write request, level; bit i = requester i
- `wdata`  in  N*W  requester data; slice i = `wdata[i*W +: W]`
- `grant`  out  N  one-hot, high for the whole transaction of the winner
- `done`  out  N  one-cycle pulse to the winner on its last transaction cycle
- `busy`  out  1  high in any state other than IDLE
- `latch_en`  out  1  to latch `clock`; high only in GATE
- `latch_d`  out  W  to latch `d`; registered, changes only on IDLE→SETUP

## Operation
- All outputs are registered. Reset values: `grant`=0, `done`=0, `busy`=0, `latch_en`=0, `latch_d`=0, state=IDLE, RR pointer=0, gate counter=0.
- FSM states: IDLE → SETUP → GATE → HOLD → IDLE.
  - IDLE: if `req`≠0, select a winner, then on the edge: set `grant[win]`=1, load `latch_d`←`wdata` slice of the winner, go to SETUP. If `req`=0, stay in IDLE.
  - SETUP (1 cycle): `latch_en`=0, `latch_d` stable. Go to GATE with counter=0.
  - GATE (`GATE_CYCLES` cycles): `latch_en`=1. Counter increments each cycle. Leave for HOLD when counter=`GATE_CYCLES`-1.
  - HOLD (1 cycle): `latch_en`=0, `latch_d` still stable, `done[win]`=1. On the edge, clear `grant` and `done` and go to IDLE.
- Data is captured at grant time. After `grant` rises, `wdata` may change freely.
- `req` is sampled only in IDLE. Deasserting `req` mid-transaction does not abort the transaction; it completes and `done` still pulses.
- Requesters wanting another write must hold `req` through `done`; the request is re-arbitrated in the next IDLE cycle.
- Gate counter width is `$clog2(GATE_CYCLES)`, minimum 1 bit. The counter is cleared on every SETUP→GATE transition.

## Timing
- A request seen in IDLE at cycle 0 produces:
  - `grant` and `busy` in cycles 1..`GATE_CYCLES`+2
  - `latch_en` in cycles 2..`GATE_CYCLES`+1
  - `done` in cycle `GATE_CYCLES`+2
- Transaction length is `GATE_CYCLES`+2 cycles, followed by at least 1 IDLE cycle. Back-to-back throughput is 1 write per `GATE_CYCLES`+3 cycles.
- `latch_d` is stable for ≥1 cycle before the `latch_en` rise and ≥1 cycle after its fall.
- Reset asserted in any state: all outputs take their reset values at that edge, and `latch_en` drops on that same edge. Any in-flight transaction is lost and no `done` is issued. `latch_d` is cleared, but the latch itself keeps its contents because the gate is closed.
- Simultaneous requests are resolved in the IDLE cycle only; there is no preemption.

## Configuration
- `LATCH_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The pointer p marks the highest-priority requester; search order is p, p+1, … mod N.
  - After granting i, p←(i+1) mod N. The pointer updates only on a grant.
- Not defined: fixed priority; the lowest index wins. The pointer logic is absent.

## Test plan
- Single request, N=4, W=8, G=2. `req`=4'b0010, `wdata[15:8]`=8'hA5 at cycle 0:
  - `grant`=4'b0010 in cycles 1–4
  - `latch_en`=1 in cycles 2–3
  - `latch_d`=8'hA5 in cycles 1–4
  - `done[1]`=1 only in cycle 4
- Data independence: change `wdata[15:8]` to 8'h3C in cycle 2 → `latch_d` stays 8'hA5 for the whole transaction.
- Contention: `req`=4'b1111 held continuously.
  - With RR: grant order 0,1,2,3,0.
  - Without RR: always 0.
  - Either way, each grant is separated by 1 IDLE cycle (period 5 cycles).
- Early deassert: `req`=4'b0100 in cycle 0, then 0 from cycle 1 → the transaction still completes, with `done[2]` in cycle 4.
- Reset mid-GATE: assert `reset` in cycle 2 → at that edge `latch_en`, `grant`, `busy` and `latch_d` all read 0 and `done` never pulses. After reset is released, a `req`=4'b1111 grants requester 0.
- G=1 build: `latch_en` is high for exactly 1 cycle, and `done` arrives in cycle 3.
